mpu_spi_arbiter: RTL and testbench



---
 rtl/mpu_spi_pkg.sv | 43 ++++
 rtl/mpu_spi_arbiter_if.sv | 31 +++
 rtl/mpu_rr_pick.sv | 32 +++
 rtl/mpu_spi_arbiter.sv | 153 +++++++++++++++
 tb/tb_mpu_spi_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mpu_spi_pkg.sv
// Shared types and constants for the MPU9250 SPI arbiter slice: state encoding,
// bus widths, requester indices and MPU9250 register map entries.
package mpu_spi_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ID_W   = 2;

  localparam int unsigned GYRO  = 0;
  localparam int unsigned ACCEL = 1;
  localparam int unsigned MAG   = 2;

  localparam logic [ADDR_W-1:0] REG_INT_PIN_CFG  = 7'h37;
  localparam logic [ADDR_W-1:0] REG_ACCEL_XOUT_H = 7'h3B;
  localparam logic [ADDR_W-1:0] REG_ACCEL_XOUT_L = 7'h3C;
  localparam logic [ADDR_W-1:0] REG_ACCEL_YOUT_H = 7'h3D;
  localparam logic [ADDR_W-1:0] REG_ACCEL_YOUT_L = 7'h3E;
  localparam logic [ADDR_W-1:0] REG_ACCEL_ZOUT_H = 7'h3F;
  localparam logic [ADDR_W-1:0] REG_ACCEL_ZOUT_L = 7'h40;
  localparam logic [ADDR_W-1:0] REG_GYRO_XOUT_H  = 7'h43;
  localparam logic [ADDR_W-1:0] REG_GYRO_XOUT_L  = 7'h44;
  localparam logic [ADDR_W-1:0] REG_GYRO_YOUT_H  = 7'h45;
  localparam logic [ADDR_W-1:0] REG_GYRO_YOUT_L  = 7'h46;
  localparam logic [ADDR_W-1:0] REG_GYRO_ZOUT_H  = 7'h47;
  localparam logic [ADDR_W-1:0] REG_GYRO_ZOUT_L  = 7'h48;
  localparam logic [ADDR_W-1:0] REG_PWR_MGMT_1   = 7'h6B;
  localparam logic [ADDR_W-1:0] REG_WHO_AM_I     = 7'h75;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DONE
  } arb_state_e;

  // Requester index following idx, wrapping at n.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return idx + ID_W'(1);
  endfunction

endpackage

// File: rtl/mpu_spi_arbiter_if.sv
// Requester-side and engine-side buses of the shared MPU9250 SPI arbiter.
interface mpu_req_if import mpu_spi_pkg::*; #(parameter int unsigned N_REQ = 3);
  logic [N_REQ-1:0]        req;
  logic [ADDR_W*N_REQ-1:0] req_addr;
  logic [DATA_W*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]        req_rw;
  logic [N_REQ-1:0]        done;
  logic [N_REQ-1:0]        err;
  logic [DATA_W-1:0]       rdata;
  logic [ID_W-1:0]         gnt_id;
  logic                    arb_busy;

  modport master (output req, req_addr, req_wdata, req_rw,
                  input  done, err, rdata, gnt_id, arb_busy);
  modport slave  (input  req, req_addr, req_wdata, req_rw,
                  output done, err, rdata, gnt_id, arb_busy);
endinterface

interface mpu_eng_if import mpu_spi_pkg::*;;
  logic [ADDR_W-1:0] mpu_address;
  logic [DATA_W-1:0] mpu_wr_data;
  logic              mpu_rd_wr_sel;
  logic              start;
  logic              busy;
  logic [DATA_W-1:0] mpu_rd_data;

  modport master (output mpu_address, mpu_wr_data, mpu_rd_wr_sel, start,
                  input  busy, mpu_rd_data);
  modport slave  (input  mpu_address, mpu_wr_data, mpu_rd_wr_sel, start,
                  output busy, mpu_rd_data);
endinterface

// File: rtl/mpu_rr_pick.sv
// Combinational rotating-priority picker: first asserted req at or after ptr wins.
module mpu_rr_pick import mpu_spi_pkg::*; #(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  win_idx_c,
  output logic             win_vld_c
);
  localparam int unsigned SW = ID_W + 1;

  logic [SW-1:0]   sum;
  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    win_idx_c = '0;
    win_vld_c = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      idx = sum[ID_W-1:0];
      if (req[idx]) begin
        win_idx_c = idx;
        win_vld_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpu_spi_arbiter.sv
// Round-robin arbiter sharing one MPU9250 SPI transaction engine among the
// gyro, accel and magnetometer controllers, with busy-handshake timeout.
module mpu_spi_arbiter import mpu_spi_pkg::*; #(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  mpu_req_if.slave   req_bus,
  mpu_eng_if.master  eng_bus
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic              start_q, start_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              arb_busy_q, arb_busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ID_W-1:0]   pick_idx_c;
  logic              pick_vld_c;
  logic              fin_c, tmo_c;

  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign addr_a[i]  = req_bus.req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_bus.req_wdata[i*DATA_W +: DATA_W];
  end

  mpu_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (req_bus.req),
    .ptr       (ptr_q),
    .win_idx_c (pick_idx_c),
    .win_vld_c (pick_vld_c)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    rdata_d    = rdata_q;
    start_d    = 1'b0;
    done_d     = '0;
    err_d      = '0;
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    fin_c      = 1'b0;
    tmo_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld_c) begin
          gnt_d   = pick_idx_c;
          addr_d  = addr_a[pick_idx_c];
          wdata_d = wdata_a[pick_idx_c];
          rw_d    = req_bus.req_rw[pick_idx_c];
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (eng_bus.busy) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fin_c = 1'b1;
          tmo_c = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!eng_bus.busy) begin
          fin_c = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          fin_c = 1'b1;
          tmo_c = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Completion: pulses land in DONE, pointer moves past the owner.
    if (fin_c) begin
      state_d = S_DONE;
      done_d  = N_REQ'(1) << gnt_q;
      ptr_d   = rr_next(gnt_q, N_REQ);
      if (tmo_c) begin
        err_d   = N_REQ'(1) << gnt_q;
        rdata_d = '0;
      end else if (rw_q) begin
        rdata_d = eng_bus.mpu_rd_data;
      end
    end

    arb_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b1;
      start_q    <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      arb_busy_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      arb_busy_q <= arb_busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign eng_bus.mpu_address   = addr_q;
  assign eng_bus.mpu_wr_data   = wdata_q;
  assign eng_bus.mpu_rd_wr_sel = rw_q;
  assign eng_bus.start         = start_q;
  assign req_bus.done          = done_q;
  assign req_bus.err           = err_q;
  assign req_bus.rdata         = rdata_q;
  assign req_bus.gnt_id        = gnt_q;
  assign req_bus.arb_busy      = arb_busy_q;

endmodule

// File: tb/tb_mpu_spi_arbiter.sv
// Scoreboard bench for mpu_spi_arbiter: expected completions are queued as
// requests are posted and retired against done pulses from the DUT.
module tb_mpu_spi_arbiter;
  import mpu_spi_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mpu_req_if #(.N_REQ(N)) rq ();
  mpu_eng_if              eng ();

  mpu_spi_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .req_bus (rq.slave),
    .eng_bus (eng.master)
  );

  typedef struct {
    int         id;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  int         n_pass = 0;
  int         n_chk  = 0;
  logic [7:0] model_rdata;
  int         rem [N];
  int         cyc = 0;
  int         start_cyc = 0;
  int         n_start = 0;
  logic       prev_start = 1'b0;

  logic       eng_en;
  int         eng_len;
  logic       eng_act;
  int         eng_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Queue an expected completion; rdata follows the bench's own read/write/timeout model.
  task automatic expect_txn(input int id, input logic rw, input logic [6:0] addr,
                            input logic [7:0] wdata, input logic err);
    exp_t e;
    e.id = id; e.rw = rw; e.addr = addr; e.wdata = wdata; e.err = err;
    if (err)     model_rdata = 8'h00;
    else if (rw) model_rdata = {1'b0, addr} ^ 8'h19;
    e.rdata = model_rdata;
    exp_q.push_back(e);
  endtask

  task automatic arm(input int id, input logic rw, input logic [6:0] addr,
                     input logic [7:0] wdata, input int count);
    rq.req_addr[id*7 +: 7]  = addr;
    rq.req_wdata[id*8 +: 8] = wdata;
    rq.req_rw[id]           = rw;
    rem[id]                 = count;
    rq.req[id]              = 1'b1;
  endtask

  task automatic wait_quiet(input int budget);
    int b = 0;
    while ((exp_q.size() != 0 || rq.req != '0 || rq.arb_busy) && b < budget) begin
      @(negedge clk);
      b++;
    end
    check("quiet_budget", 32'(b < budget), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"},  32'(eng.start),         32'd0);
    check({tag, "_addr"},   32'(eng.mpu_address),   32'd0);
    check({tag, "_wdata"},  32'(eng.mpu_wr_data),   32'd0);
    check({tag, "_rwsel"},  32'(eng.mpu_rd_wr_sel), 32'd1);
    check({tag, "_done"},   32'(rq.done),           32'd0);
    check({tag, "_err"},    32'(rq.err),            32'd0);
    check({tag, "_rdata"},  32'(rq.rdata),          32'd0);
    check({tag, "_gnt"},    32'(rq.gnt_id),         32'd0);
    check({tag, "_abusy"},  32'(rq.arb_busy),       32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: busy rises the edge after start and holds for eng_len cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng.busy        <= 1'b0;
      eng.mpu_rd_data <= 8'h00;
      eng_act         <= 1'b0;
      eng_cnt         <= 0;
    end else if (!eng_act) begin
      if (eng.start && eng_en) begin
        eng_act  <= 1'b1;
        eng.busy <= 1'b1;
        eng_cnt  <= eng_len;
      end
    end else if (eng_cnt <= 1) begin
      eng_act  <= 1'b0;
      eng.busy <= 1'b0;
      if (eng.mpu_rd_wr_sel) eng.mpu_rd_data <= {1'b0, eng.mpu_address} ^ 8'h19;
    end else begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  // Monitor plus requester behaviour: check starts and dones, drop req when finished.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng.start) begin
        n_start++;
        start_cyc = cyc;
        check("start_pulse_len", 32'(prev_start), 32'd0);
        if (exp_q.size() == 0) begin
          check("start_unexpected", 32'd1, 32'd0);
        end else begin
          check("start_gnt_id", 32'(rq.gnt_id),        32'(exp_q[0].id));
          check("start_addr",   32'(eng.mpu_address),  32'(exp_q[0].addr));
          check("start_rwsel",  32'(eng.mpu_rd_wr_sel), 32'(exp_q[0].rw));
          if (!exp_q[0].rw) check("start_wdata", 32'(eng.mpu_wr_data), 32'(exp_q[0].wdata));
        end
      end
      if (rq.done != '0) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'(rq.done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_vec",  32'(rq.done),   32'd1 << e.id);
          check("err_vec",   32'(rq.err),    e.err ? (32'd1 << e.id) : 32'd0);
          check("rdata",     32'(rq.rdata),  32'(e.rdata));
          check("done_gnt",  32'(rq.gnt_id), 32'(e.id));
          if (e.err) check("timeout_latency", 32'(cyc - start_cyc), 32'(TO));
        end
        for (int i = 0; i < int'(N); i++) begin
          if (rq.done[i] && rem[i] > 0) begin
            rem[i]--;
            if (rem[i] == 0) rq.req[i] = 1'b0;
          end
        end
      end else if (rq.err != '0) begin
        check("err_without_done", 32'(rq.err), 32'd0);
      end
      prev_start = eng.start;
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int s0;
    rst_n        = 1'b0;
    rq.req       = '0;
    rq.req_addr  = '0;
    rq.req_wdata = '0;
    rq.req_rw    = '0;
    model_rdata  = 8'h00;
    eng_en       = 1'b1;
    eng_len      = 8;
    for (int i = 0; i < int'(N); i++) rem[i] = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read from gyro: start exactly one cycle after the sampling edge.
    expect_txn(GYRO, 1'b1, REG_GYRO_XOUT_H, 8'h00, 1'b0);
    arm(GYRO, 1'b1, REG_GYRO_XOUT_H, 8'h00, 1);
    @(posedge clk);
    @(negedge clk);
    check("start_latency", 32'(eng.start), 32'd1);
    wait_quiet(100);
    check("read_rdata_5a", 32'(rq.rdata), 32'h5A);

    // Write from accel leaves rdata alone.
    expect_txn(ACCEL, 1'b0, REG_PWR_MGMT_1, 8'h00, 1'b0);
    arm(ACCEL, 1'b0, REG_PWR_MGMT_1, 8'h00, 1);
    wait_quiet(100);
    check("write_rdata_kept", 32'(rq.rdata), 32'h5A);

    // Timeout: engine ignores start.
    eng_en = 1'b0;
    expect_txn(MAG, 1'b1, REG_WHO_AM_I, 8'h00, 1'b1);
    arm(MAG, 1'b1, REG_WHO_AM_I, 8'h00, 1);
    wait_quiet(100);
    check("timeout_rdata", 32'(rq.rdata), 32'h00);
    eng_en = 1'b1;

    // Contention: pointer is back at 0, so grants rotate 0,1,2,0,1,2.
    eng_len = 3;
    s0 = n_start;
    for (int r = 0; r < 2; r++) begin
      expect_txn(0, 1'b1, REG_ACCEL_XOUT_H, 8'h00, 1'b0);
      expect_txn(1, 1'b1, REG_ACCEL_YOUT_H, 8'h00, 1'b0);
      expect_txn(2, 1'b1, REG_ACCEL_ZOUT_H, 8'h00, 1'b0);
    end
    arm(0, 1'b1, REG_ACCEL_XOUT_H, 8'h00, 2);
    arm(1, 1'b1, REG_ACCEL_YOUT_H, 8'h00, 2);
    arm(2, 1'b1, REG_ACCEL_ZOUT_H, 8'h00, 2);
    wait_quiet(300);
    check("contention_starts", 32'(n_start - s0), 32'd6);

    // Leave the pointer at 2, then reset in the middle of a mag transaction.
    expect_txn(ACCEL, 1'b0, 7'h1B, 8'h18, 1'b0);
    arm(ACCEL, 1'b0, 7'h1B, 8'h18, 1);
    wait_quiet(100);
    eng_len = 20;
    expect_txn(MAG, 1'b1, REG_INT_PIN_CFG, 8'h00, 1'b0);
    arm(MAG, 1'b1, REG_INT_PIN_CFG, 8'h00, 1);
    b = 0;
    while (!eng.busy && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("reach_wait_done", 32'(eng.busy), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    rem[MAG]   = 0;
    rq.req     = '0;
    model_rdata = 8'h00;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_idle", 32'(rq.arb_busy), 32'd0);

    // Pointer restarted at 0: accel wins over mag.
    eng_len = 4;
    expect_txn(ACCEL, 1'b1, 7'h41, 8'h00, 1'b0);
    expect_txn(MAG,   1'b0, 7'h1C, 8'h08, 1'b0);
    arm(ACCEL, 1'b1, 7'h41, 8'h00, 1);
    arm(MAG,   1'b0, 7'h1C, 8'h08, 1);
    wait_quiet(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
